// File: rtl/rstack_seq_if.sv
// Core-side port bundle for the return-stack sequencer.
//
// Handshake: the core raises push or pop (with push_addr) while busy is low;
// the sequencer samples the request on that rising edge. An accepted request
// raises busy for four cycles, then done pulses for one cycle. A rejected
// request leaves busy low and pulses err for one cycle. Requests seen while
// busy is high are dropped, not queued.
interface rstack_seq_if;
    logic        push;
    logic        pop;
    logic [11:0] push_addr;
    logic [11:0] pop_addr;
    logic        busy;
    logic        done;
    logic        err;
    logic        empty;
    logic        full;

    modport master (
        output push, pop, push_addr,
        input  pop_addr, busy, done, err, empty, full
    );

    modport slave (
        input  push, pop, push_addr,
        output pop_addr, busy, done, err, empty, full
    );
endinterface

// File: rtl/rstack_seq.sv
// Return-stack sequencer: stores 12-bit return addresses as four 3-bit triads
// (least-significant first) in a LIFO region of an external 3-bit word RAM.
// RAM-side outputs are decoded purely from registered state.
module rstack_seq #(
    parameter logic [11:0] BASE  = 12'hE00,
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    rstack_seq_if.slave core,
    output logic        R_F,
    output logic [11:0] Address,
    output logic [2:0]  Data_In,
    input  logic [2:0]  Data_Out,
    output logic [1:0]  state_dbg
);
    localparam int SPW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [1:0]     k_q, k_d;
    logic [11:0]    data_q, data_d;       // latched address being pushed
    logic [11:0]    shadow_q, shadow_d;   // triads gathered during a pop
    logic [11:0]    pop_addr_q, pop_addr_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic           is_empty, is_full;
    logic [SPW-1:0] sp_top;               // index of the top entry (sp-1)

    assign is_empty = (sp_q == '0);
    assign is_full  = (sp_q == SPW'(DEPTH));
    assign sp_top   = sp_q - SPW'(1);

    assign core.busy     = (state_q != IDLE);
    assign core.done     = done_q;
    assign core.err      = err_q;
    assign core.empty    = is_empty;
    assign core.full     = is_full;
    assign core.pop_addr = pop_addr_q;
    assign state_dbg     = state_q;

    // Registered state; reset returns everything to the idle/empty condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sp_q       <= '0;
            k_q        <= 2'd0;
            data_q     <= 12'h000;
            shadow_q   <= 12'h000;
            pop_addr_q <= 12'h000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            k_q        <= k_d;
            data_q     <= data_d;
            shadow_q   <= shadow_d;
            pop_addr_q <= pop_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Request decode, triad stepping and completion bookkeeping.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        k_d        = k_q;
        data_d     = data_q;
        shadow_d   = shadow_q;
        pop_addr_d = pop_addr_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (core.push && core.pop) begin
                    err_d = 1'b1;
                end else if (core.push) begin
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = core.push_addr;
                        k_d     = 2'd0;
                        state_d = PUSH;
                    end
                end else if (core.pop) begin
                    if (is_empty) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = 2'd0;
                        state_d = POP;
                    end
                end
            end
            PUSH: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    sp_d    = sp_q + SPW'(1);
                    k_d     = 2'd0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            POP: begin
                case (k_q)
                    2'd0:    shadow_d[2:0]  = Data_Out;
                    2'd1:    shadow_d[5:3]  = Data_Out;
                    2'd2:    shadow_d[8:6]  = Data_Out;
                    default: shadow_d[11:9] = Data_Out;
                endcase
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    pop_addr_d = shadow_d;
                    sp_d       = sp_top;
                    k_d        = 2'd0;
                    done_d     = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM-side drive, decoded from registered state only.
    always_comb begin
        R_F     = 1'b0;
        Address = BASE;
        Data_In = 3'd0;
        case (state_q)
            PUSH: begin
                R_F     = 1'b1;
                Address = BASE + (12'(sp_q) << 2) + {10'd0, k_q};
                case (k_q)
                    2'd0:    Data_In = data_q[2:0];
                    2'd1:    Data_In = data_q[5:3];
                    2'd2:    Data_In = data_q[8:6];
                    default: Data_In = data_q[11:9];
                endcase
            end
            POP: begin
                Address = BASE + (12'(sp_top) << 2) + {10'd0, k_q};
            end
            default: begin
                R_F     = 1'b0;
            end
        endcase
    end
endmodule
